// File: rtl/spi_master.sv
// SPI master: sends a mode bit plus a 10-bit command word, and for read-data commands captures a byte from MISO.
// Optional abort input is enabled by defining SPI_MASTER_ABORT_EN.
module spi_master #(
    parameter int READ_WAIT = 2,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE+1:0] cmd_data,
`ifdef SPI_MASTER_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int W = ADDR_SIZE + 2;
    localparam logic [3:0] SHIFT_LAST = 4'(W - 1);
    localparam logic [3:0] WAIT_LAST  = 4'(READ_WAIT - 1);
    localparam logic [3:0] READ_LAST  = 4'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_MODE, S_SHIFT, S_WAIT, S_READ, S_END
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [W-1:0]         sh;
    logic [ADDR_SIZE-1:0] rx;
    logic                 is_rd;

    // Outputs are assigned for the state being entered, so they are valid in that state's cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sh       <= '0;
            rx       <= '0;
            is_rd    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_START;
                        sh    <= cmd_data;
                        is_rd <= (cmd_data[W-1:W-2] == 2'b11);
                        busy  <= 1'b1;
                        SS_n  <= 1'b0;
                        MOSI  <= 1'b0;
                    end
                end
                S_START: begin
                    state <= S_MODE;
                    MOSI  <= sh[W-1];
                end
                S_MODE: begin
                    // The mode bit repeats cmd[9], so the shift register only starts moving here.
                    state <= S_SHIFT;
                    MOSI  <= sh[W-1];
                    sh    <= sh << 1;
                    cnt   <= '0;
                end
                S_SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        cnt  <= '0;
                        MOSI <= 1'b0;
                        if (is_rd) begin
                            state <= S_WAIT;
                        end else begin
                            state <= S_END;
                            SS_n  <= 1'b1;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt + 4'd1;
                        MOSI <= sh[W-1];
                        sh   <= sh << 1;
                    end
                end
                S_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= S_READ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_READ: begin
                    rx <= {rx[ADDR_SIZE-2:0], MISO};
                    if (cnt == READ_LAST) begin
                        cnt      <= '0;
                        state    <= S_END;
                        rd_data  <= {rx[ADDR_SIZE-2:0], MISO};
                        rd_valid <= 1'b1;
                        done     <= 1'b1;
                        SS_n     <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                end
            endcase
`ifdef SPI_MASTER_ABORT_EN
            // Abort wins over any normal transition, including a read that completes on this edge.
            if (abort && state != S_IDLE && state != S_END) begin
                state    <= S_END;
                cnt      <= '0;
                SS_n     <= 1'b1;
                MOSI     <= 1'b0;
                done     <= 1'b1;
                rd_valid <= 1'b0;
                rd_data  <= rd_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: frame-offset reference model checked every cycle, plus directed literal checks.
module tb_spi_master;

    localparam int RW = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       miso = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] cmd_data = '0;
    logic       busy, done, rd_valid, ss_n, mosi;
    logic [7:0] rd_data;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    spi_master #(.READ_WAIT(RW), .ADDR_SIZE(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cmd_data(cmd_data),
`ifdef SPI_MASTER_ABORT_EN
        .abort(abort),
`endif
        .busy(busy),
        .done(done),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .SS_n(ss_n),
        .MOSI(mosi),
        .MISO(miso)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: k is the cycle offset from the accept cycle (0 = idle).
    int         k = 0;
    logic [9:0] m_cmd = '0;
    bit         m_rd = 0;
    bit         m_abrt = 0;
    logic [7:0] m_byte = '0;
    logic [7:0] exp_rd = '0;
    bit         model_live = 0;
    bit         fixed_slave = 0;
    logic [7:0] slave_byte = '0;

    function automatic int frame_len();
        return m_rd ? 21 + RW : 13;
    endfunction

    function automatic logic [12:0] exp_vec();
        logic ss, mo, bz, dn, vl;
        ss = 1'b1; mo = 1'b0; bz = (k != 0); dn = 1'b0; vl = 1'b0;
        if (k != 0 && k == frame_len()) begin
            dn = 1'b1;
            vl = m_rd && !m_abrt;
        end else if (k != 0) begin
            ss = 1'b0;
            if (k == 2) mo = m_cmd[9];
            else if (k >= 3 && k <= 12) mo = m_cmd[12 - k];
        end
        return {ss, mo, bz, dn, vl, exp_rd};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            k = 0;
            exp_rd = '0;
        end else if (k == 0) begin
            if (start) begin
                k = 1;
                m_cmd = cmd_data;
                m_rd = (cmd_data[9:8] == 2'b11);
                m_abrt = 0;
                m_byte = '0;
            end
        end else if (k == frame_len()) begin
            k = 0;
        end else if (abort) begin
            k = frame_len();
            m_abrt = 1;
        end else begin
            if (m_rd && k >= 13 + RW && k <= 20 + RW) m_byte[20 + RW - k] = miso;
            k++;
            if (k == frame_len() && m_rd) exp_rd = m_byte;
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live)
            check("cycle_outputs", 16'({ss_n, mosi, busy, done, rd_valid, rd_data}), 16'(exp_vec()));
    end

    // Slave: presents one byte MSB first across the read window, noise elsewhere.
    always @(negedge clk) begin
        if (k == 12 && !fixed_slave) slave_byte = 8'($urandom);
        if (m_rd && k >= 13 + RW && k <= 20 + RW) miso = slave_byte[20 + RW - k];
        else miso = 1'($urandom);
    end

    task automatic send(input logic [9:0] c);
        start = 1'b1;
        cmd_data = c;
        @(negedge clk);
        start = 1'b0;
        cmd_data = 10'($urandom);
    endtask

    initial begin
        logic [10:0] seq;
        int run;
        bit seen_low;

        rst_n = 1'b0;
        start = 1'b1;
        cmd_data = 10'h3FF;
        repeat (3) @(negedge clk);
        check("reset_ss_n", 16'(ss_n), 16'd1);
        check("reset_mosi", 16'(mosi), 16'd0);
        check("reset_busy", 16'(busy), 16'd0);
        check("reset_rd_data", 16'(rd_data), 16'h00);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);

        // Write address frame
        send(10'b00_1010_0101);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            seq[10 - i] = mosi;
        end
        check("write_mosi_seq", 16'(seq), 16'(11'b0_0010100101));
        @(negedge clk);
        check("write_done_n13", 16'(done), 16'd1);
        check("write_rd_valid", 16'(rd_valid), 16'd0);
        @(negedge clk);

        // Read-data frame
        fixed_slave = 1;
        slave_byte = 8'hC3;
        send(10'b11_0000_0000);
        repeat (21) @(negedge clk);
        check("read_done_early", 16'(done), 16'd0);
        @(negedge clk);
        check("read_done_n23", 16'(done), 16'd1);
        check("read_rd_valid", 16'(rd_valid), 16'd1);
        check("read_rd_data", 16'(rd_data), 16'hC3);
        @(negedge clk);

`ifdef SPI_MASTER_ABORT_EN
        slave_byte = 8'h5A;
        send(10'b11_0101_0101);
        repeat (17) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", 16'(done), 16'd1);
        check("abort_rd_valid", 16'(rd_valid), 16'd0);
        check("abort_rd_data", 16'(rd_data), 16'hC3);
        @(negedge clk);
`endif
        fixed_slave = 0;

        // Back-to-back with start held high
        run = 0;
        seen_low = 0;
        start = 1'b1;
        repeat (90) begin
            @(negedge clk);
            cmd_data = 10'($urandom);
            if (ss_n) begin
                run++;
            end else begin
                if (seen_low && run > 0) check("b2b_ss_high_run", 16'(run), 16'd2);
                run = 0;
                seen_low = 1;
            end
        end
        start = 1'b0;
        repeat (30) @(negedge clk);

        // Mid-frame reset at SHIFT bit 4, then a clean frame
        send(10'h155);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ss_n", 16'(ss_n), 16'd1);
        check("midrst_done", 16'(done), 16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        send(10'b10_1100_0011);
        repeat (12) @(negedge clk);
        check("after_rst_done", 16'(done), 16'd1);
        @(negedge clk);

        // Random traffic
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            cmd_data = 10'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
`ifdef SPI_MASTER_ABORT_EN
            abort = ($urandom_range(0, 39) == 0);
`endif
        end
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
